// File: rtl/serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl_if
//   Request/response bundle between a requesting controller (master) and the
//   bit-serial adder sequencer (slave).
//   start  : request, only honoured while the sequencer is idle
//   a, b   : operands, captured on the accepted start edge
//   busy   : sequencer is stepping through bit-cycles
//   done   : one-cycle pulse, s/cout valid
//   s, cout: registered result, held until the next completion
// ---------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (
        output start, a, b,
        input  busy, done, s, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, s, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder sequencer. One full-adder cell (two half adders and an
//   OR) is reused over WIDTH cycles to form {cout, s} = a + b.
//   clk_i   : rising-edge clock
//   rst_n_i : asynchronous active-low reset, clears every register
//   bus     : serial_add_ctrl_if slave side (start/a/b in, busy/done/s/cout out)
// ---------------------------------------------------------------------------

// Half-adder cell; two of these plus an OR make the shared full adder.
module serial_add_ha (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    serial_add_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    logic [WIDTH-1:0] shr_q, shr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;

    // Shared full-adder cell on the LSBs of the operand shifters.
    logic s1, c1, sum_bit, c2, c_next;

    serial_add_ha u_ha0 (.a_i(sha_q[0]), .b_i(shb_q[0]), .s_o(s1),      .c_o(c1));
    serial_add_ha u_ha1 (.a_i(s1),       .b_i(carry_q),  .s_o(sum_bit), .c_o(c2));
    assign c_next = c1 | c2;

    // Result shifter with the current sum bit entering from the MSB side;
    // after WIDTH steps bit 0 of the sum has reached bit 0.
    logic [WIDTH-1:0] shr_next;
    assign shr_next = {sum_bit, shr_q[WIDTH-1:1]};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            shr_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            shr_q   <= shr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        shr_d   = shr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sha_d   = bus.a;
                    shb_d   = bus.b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sha_d   = sha_q >> 1;
                shb_d   = shb_q >> 1;
                shr_d   = shr_next;
                carry_d = c_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last bit-cycle: publish the full result including this bit.
                    s_d     = shr_next;
                    cout_d  = c_next;
                    cnt_d   = '0;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake decoded purely from registered state, so glitch-free and
    // mutually exclusive.
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == FIN);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
endmodule
